// File: rtl/sram_pkg.sv
// Shared types and helpers for the clocked byte-addressable SRAM controller.
package sram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned BE_W_MAX   = 64;
  localparam int unsigned DATA_W_MAX = BE_W_MAX * 8;

  // Expand one enable bit per byte into a full bit mask (caller truncates to DATA_W).
  function automatic logic [DATA_W_MAX-1:0] be_to_mask(input logic [BE_W_MAX-1:0] be);
    logic [DATA_W_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W_MAX; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Fixed-latency read response pipeline carrying {valid, data, err}; flushed by rst.
module sram_rd_pipe
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_err,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int unsigned LAT = (RD_LAT < 1) ? 1 :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  logic [LAT-1:0]    v;
  logic [LAT-1:0]    e;
  logic [DATA_W-1:0] d [LAT];

  // Idle slots carry zero data/err so the outputs hold 0 between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      e <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      e[0] <= in_valid & in_err;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        e[i] <= e[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_valid = v[LAT-1];
  assign out_err   = e[LAT-1];
  assign out_data  = d[LAT-1];

endmodule

// File: rtl/sram_ctrl.sv
// Single-port byte-addressable SRAM with valid/ready requests, zero-init and masked reads.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned INIT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  init_done
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CMP_W = ADDR_W + 1;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              clr_en;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request decode; the extra compare bit keeps DEPTH == 2**ADDR_W from wrapping.
  assign in_range = ({1'b0, req_addr} < CMP_W'(DEPTH));
  assign accept   = req_valid & req_ready & ~rst;
  assign idx      = IDX_W'(req_addr);
  assign mask     = DATA_W'(be_to_mask(BE_W_MAX'(req_be)));
  assign rd_word  = mem[idx];
  assign rd_data  = in_range ? (rd_word & mask) : '0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_en    = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_en  = 1'b1;
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_W'(DEPTH - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (INIT_ZERO != 0) ? CLEAR : RUN;
      cnt       <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == RUN);
      init_done <= init_done | (state_nxt == RUN);
    end
  end

  // Array has no reset; rst only gates writes so an edge coinciding with rst commits nothing.
  always_ff @(posedge clk) begin
    if (clr_en && !rst) begin
      mem[IDX_W'(cnt)] <= '0;
    end else if (accept && req_we && in_range) begin
      mem[idx] <= (rd_word & ~mask) | (req_wdata & mask);
    end
  end

  sram_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept & ~req_we),
    .in_data   (rd_data),
    .in_err    (~in_range),
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata),
    .out_err   (rsp_err)
  );

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Parametrised, clocked, byte-addressable single-port SRAM with a valid/ready request interface and a configurable read-latency pipeline. It succeeds the unclocked, pulse-driven 128x32 SRAM. New capabilities over that SRAM:
- hardware zero-initialisation after reset
- masked (byte-lane) reads
- out-of-range error reporting
It sits between the core load/store unit and the on-chip memory array.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 7, word-address width.
- DEPTH, 128, number of words implemented; must be ≤ 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from accept to response; legal range 1..4.
- INIT_ZERO, 1, when 1, clear every word to zero after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_be  in  DATA_W/8  byte enables; bit i covers bits [8i+7:8i].
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  read response valid (one-cycle pulse per read).
- rsp_rdata  out  DATA_W  read data, masked by the captured req_be.
- rsp_err  out  1  response is for an address ≥ DEPTH.
- init_done  out  1  high once clearing is complete; stays high until the next rst.

Behaviour:
- Reset values (asynchronous, immediate on rst=1):
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0.
  - Read pipeline flushed; clear counter=0.
  - Array contents are not reset by rst itself.
- FSM states: CLEAR, RUN.
  - After rst deasserts, enter CLEAR if INIT_ZERO=1, otherwise RUN.
  - CLEAR writes 0 to word k on cycle k, for k = 0..DEPTH-1. After the DEPTH-1 write, go to RUN.
  - init_done rises on the first RUN cycle. With INIT_ZERO=0, this is the first clock edge after rst falls.
- req_ready = 1 in RUN, 0 in CLEAR. No other backpressure source exists.
- Accept = req_valid & req_ready at a rising edge. At most one request per cycle.
- Write:
  - For each i with req_be[i]=1, byte i of word req_addr takes req_wdata byte i. Other bytes are unchanged.
  - be=0 is a legal no-op.
  - No response is generated.
- Read:
  - rsp_valid pulses exactly RD_LAT cycles after accept.
  - rsp_rdata byte i = stored byte if the captured be[i]=1, else 0x00.
  - Back-to-back reads give back-to-back responses, in order.
- Ordering: a read accepted the cycle after a write to the same address returns the post-write value. The array write commits on the accept edge.
- Out of range (req_addr ≥ DEPTH; reachable only when DEPTH < 2**ADDR_W):
  - Write is dropped.
  - Read responds with rsp_rdata=0 and rsp_err=1 at normal latency.
- rsp_err=0 on all in-range responses. rsp_rdata and rsp_err hold 0 when rsp_valid=0.
- Reset mid-operation:
  - Pending responses are discarded; no rsp_valid follows for them.
  - A CLEAR in progress restarts from word 0.
  - A write on the edge where rst rises is not committed.
- Width rules: be width is DATA_W/8. Address comparison against DEPTH uses ADDR_W+1 bits to avoid wrap. The clear counter is $clog2(DEPTH)+1 bits.

Decomposition:
- Package sram_pkg holds:
  - state enum (CLEAR, RUN)
  - RD_LAT_MAX = 4
  - helper function for byte-mask expansion (be → DATA_W-bit mask)
- Sub-module sram_rd_pipe: RD_LAT-deep shift pipeline carrying {valid, data, err}, with asynchronous flush on rst.
- Array storage and FSM stay in sram_ctrl.

Test Plan:
1. Init clear: default params, preload array with 0xA5A5A5A5 via backdoor, pulse rst → req_ready=0 for exactly 128 cycles, then init_done=1. Full-be reads of addr 0, 64 and 127 return 0x00000000.
2. Byte-masked write: write 0x11223344 be=1111 to addr 11, then 0xFFFF0000 be=1100 → read be=1111 returns 0xFFFF3344. Read be=0011 returns 0x00003344.
3. Latency/throughput, RD_LAT=3: four back-to-back reads of addrs 0..3 holding 0x0,0x1,0x2,0x3 → rsp_valid high on cycles accept+3..accept+6, data in order.
4. RAW hazard: write 0xFACEB00C to addr 11, read addr 11 on the next cycle → rsp_rdata=0xFACEB00C.
5. Out of range, DEPTH=100 and ADDR_W=7: write 0xDEADBEEF to addr 120, then read addr 120 → rsp_err=1, rsp_rdata=0. A read of addr 99 returns rsp_err=0.
6. Reset mid-flight: issue a read with RD_LAT=4 and assert rst 2 cycles later → rsp_valid stays 0. CLEAR restarts, and init_done rises 128 cycles after rst falls.
